user_reg_master: RTL and testbench

Register-interface initiator for the PCIe clock domain. It accepts single host register reads and writes, typically decoded from PCIe memory TLPs by the RX engine. It drives them onto the user register bus (`o_user_wr_req` / `o_user_rd_req` / `o_user_addr` / `o_user_data`), which the user logic responds to. Reads wait for `i_user_rd_ack` and return data or an error completion to the host side.

---
 rtl/user_reg_master_if.sv | 32 +++
 rtl/user_reg_master.sv | 140 ++++++++++++++
 tb/tb_user_reg_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/user_reg_master_if.sv
// Host-side request/completion and user register bus signals of user_reg_master.
// The master modport is the initiator's view; slave is the view of the host and user logic around it.
interface user_reg_master_if;
    logic        i_host_valid;
    logic        o_host_ready;
    logic        i_host_wr;
    logic [19:0] i_host_addr;
    logic [31:0] i_host_data;
    logic        o_host_rd_valid;
    logic [31:0] o_host_rd_data;
    logic        o_host_rd_err;
    logic        o_user_wr_req;
    logic        o_user_rd_req;
    logic [19:0] o_user_addr;
    logic [31:0] o_user_data;
    logic [31:0] i_user_data;
    logic        i_user_rd_ack;

    modport master (
        input  i_host_valid, i_host_wr, i_host_addr, i_host_data,
        input  i_user_data, i_user_rd_ack,
        output o_host_ready, o_host_rd_valid, o_host_rd_data, o_host_rd_err,
        output o_user_wr_req, o_user_rd_req, o_user_addr, o_user_data
    );

    modport slave (
        output i_host_valid, i_host_wr, i_host_addr, i_host_data,
        output i_user_data, i_user_rd_ack,
        input  o_host_ready, o_host_rd_valid, o_host_rd_data, o_host_rd_err,
        input  o_user_wr_req, o_user_rd_req, o_user_addr, o_user_data
    );
endinterface

// File: rtl/user_reg_master.sv
// Register-bus initiator: turns single host reads/writes into user-bus strobes and read completions.
// Define USER_REG_TIMEOUT_EN to build the read timeout counter and error completion path.
module user_reg_master #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
    input logic               i_pcie_clk,
    input logic               i_rst,
    user_reg_master_if.master bus
);

    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        hostReady_q, hostReady_d;
    logic        userWrReq_q, userWrReq_d;
    logic        userRdReq_q, userRdReq_d;
    logic        rdValid_q, rdValid_d;
    logic [19:0] userAddr_q, userAddr_d;
    logic [31:0] userData_q, userData_d;
    logic [31:0] rdData_q, rdData_d;

`ifdef USER_REG_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic        rdErr_q, rdErr_d;
    logic [15:0] timeoutCnt_q, timeoutCnt_d;
`else
    logic [47:0] unusedCfg;
    assign unusedCfg = {ERR_DATA, 16'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge i_pcie_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            hostReady_q  <= 1'b0;
            userWrReq_q  <= 1'b0;
            userRdReq_q  <= 1'b0;
            rdValid_q    <= 1'b0;
            userAddr_q   <= '0;
            userData_q   <= '0;
            rdData_q     <= '0;
`ifdef USER_REG_TIMEOUT_EN
            rdErr_q      <= 1'b0;
            timeoutCnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hostReady_q  <= hostReady_d;
            userWrReq_q  <= userWrReq_d;
            userRdReq_q  <= userRdReq_d;
            rdValid_q    <= rdValid_d;
            userAddr_q   <= userAddr_d;
            userData_q   <= userData_d;
            rdData_q     <= rdData_d;
`ifdef USER_REG_TIMEOUT_EN
            rdErr_q      <= rdErr_d;
            timeoutCnt_q <= timeoutCnt_d;
`endif
        end
    end

    // Strobes and ready are registered copies of the next state, so each lines up with its state.
    always_comb begin
        state_d      = state_q;
        userAddr_d   = userAddr_q;
        userData_d   = userData_q;
        rdData_d     = rdData_q;
`ifdef USER_REG_TIMEOUT_EN
        rdErr_d      = rdErr_q;
        timeoutCnt_d = timeoutCnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_host_valid && hostReady_q) begin
                    userAddr_d = bus.i_host_addr;
                    userData_d = bus.i_host_data;
`ifdef USER_REG_TIMEOUT_EN
                    timeoutCnt_d = '0;
`endif
                    state_d = bus.i_host_wr ? WR : RD_REQ;
                end
            end
            WR: state_d = IDLE;
            RD_REQ: begin
                if (bus.i_user_rd_ack) begin
                    rdData_d = bus.i_user_data;
`ifdef USER_REG_TIMEOUT_EN
                    rdErr_d  = 1'b0;
`endif
                    state_d  = RESP;
                end else begin
`ifdef USER_REG_TIMEOUT_EN
                    timeoutCnt_d = timeoutCnt_q + 16'd1;
`endif
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // An ack arriving on the timeout cycle still wins.
                if (bus.i_user_rd_ack) begin
                    rdData_d = bus.i_user_data;
`ifdef USER_REG_TIMEOUT_EN
                    rdErr_d  = 1'b0;
`endif
                    state_d  = RESP;
                end
`ifdef USER_REG_TIMEOUT_EN
                else if (timeoutCnt_q == TIMEOUT_LAST) begin
                    rdData_d = ERR_DATA;
                    rdErr_d  = 1'b1;
                    state_d  = RESP;
                end else begin
                    timeoutCnt_d = timeoutCnt_q + 16'd1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        hostReady_d = (state_d == IDLE);
        userWrReq_d = (state_d == WR);
        userRdReq_d = (state_d == RD_REQ);
        rdValid_d   = (state_d == RESP);
    end

    assign bus.o_host_ready    = hostReady_q;
    assign bus.o_user_wr_req   = userWrReq_q;
    assign bus.o_user_rd_req   = userRdReq_q;
    assign bus.o_host_rd_valid = rdValid_q;
    assign bus.o_user_addr     = userAddr_q;
    assign bus.o_user_data     = userData_q;
    assign bus.o_host_rd_data  = rdData_q;
`ifdef USER_REG_TIMEOUT_EN
    assign bus.o_host_rd_err   = rdErr_q;
`else
    assign bus.o_host_rd_err   = 1'b0;
`endif

endmodule

// File: tb/tb_user_reg_master.sv
// Scoreboard bench for user_reg_master: directed host traffic queues expected strobes/completions,
// and a negedge monitor pops and checks them; also checks ready and reset behaviour directly.
module tb_user_reg_master;

    localparam int EV_WR = 0;
    localparam int EV_RD = 1;
    localparam int EV_RV = 2;

    typedef struct {
        int          kind;
        int          cycle;
        logic [19:0] addr;
        logic [31:0] data;
        logic        err;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nTests = 0;
    int   nFail = 0;
    int   t0;
    ev_t  expQ[$];

    user_reg_master_if bus();

    user_reg_master #(
        .TIMEOUT_CYCLES(16),
        .ERR_DATA(32'hFFFF_FFFF)
    ) dut (
        .i_pcie_clk(clk),
        .i_rst(rst),
        .bus(bus.master)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic wr, input logic [19:0] addr, input logic [31:0] data);
        bus.i_host_valid = valid;
        bus.i_host_wr    = wr;
        bus.i_host_addr  = addr;
        bus.i_host_data  = data;
    endtask

    task automatic setAck(input logic ack, input logic [31:0] data);
        bus.i_user_rd_ack = ack;
        bus.i_user_data   = data;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushExp(input int kind, input int cycle, input logic [19:0] addr, input logic [31:0] data, input logic err);
        ev_t e;
        e.kind  = kind;
        e.cycle = cycle;
        e.addr  = addr;
        e.data  = data;
        e.err   = err;
        expQ.push_back(e);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"},    32'(bus.o_host_ready),    32'd0);
        checkOutput({tag, "_wr_req"},   32'(bus.o_user_wr_req),   32'd0);
        checkOutput({tag, "_rd_req"},   32'(bus.o_user_rd_req),   32'd0);
        checkOutput({tag, "_rd_valid"}, 32'(bus.o_host_rd_valid), 32'd0);
        checkOutput({tag, "_addr"},     32'(bus.o_user_addr),     32'd0);
        checkOutput({tag, "_data"},     bus.o_user_data,          32'd0);
        checkOutput({tag, "_rd_data"},  bus.o_host_rd_data,       32'd0);
        checkOutput({tag, "_rd_err"},   32'(bus.o_host_rd_err),   32'd0);
    endtask

    task automatic handleEvent(input int kind);
        ev_t e;
        if (expQ.size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL unexpected_event kind %0d at cycle %0d: got an output pulse, expected none", kind, cyc);
        end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("ev%0d_kind", e.kind), 32'(kind), 32'(e.kind));
            checkOutput($sformatf("ev%0d_cycle", e.kind), 32'(cyc), 32'(e.cycle));
            checkOutput($sformatf("ev%0d_addr", e.kind), 32'(bus.o_user_addr), 32'(e.addr));
            if (kind == EV_WR)
                checkOutput("wr_data", bus.o_user_data, e.data);
            if (kind == EV_RV) begin
                checkOutput("rd_data", bus.o_host_rd_data, e.data);
                checkOutput("rd_err", 32'(bus.o_host_rd_err), 32'(e.err));
            end
        end
    endtask

    // Monitor: every strobe or completion seen must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_user_wr_req)   handleEvent(EV_WR);
            if (bus.o_user_rd_req)   handleEvent(EV_RD);
            if (bus.o_host_rd_valid) handleEvent(EV_RV);
        end
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 20'h0, 32'h0);
        setAck(1'b0, 32'h0);

        // Reset state and recovery
        waitCycles(3);
        checkAllZero("reset");
        rst = 1'b0;
        waitCycles(1);
        checkOutput("reset_recovery_ready", 32'(bus.o_host_ready), 32'd1);

        // Single write
        t0 = cyc;
        applyStimulus(1'b1, 1'b1, 20'h00400, 32'h1234_5678);
        pushExp(EV_WR, t0 + 1, 20'h00400, 32'h1234_5678, 1'b0);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 20'h0, 32'h0);
        checkOutput("wr_ready_T1", 32'(bus.o_host_ready), 32'd0);
        waitCycles(1);
        checkOutput("wr_ready_T2", 32'(bus.o_host_ready), 32'd1);

        // Read with registered responder
        t0 = cyc;
        applyStimulus(1'b1, 1'b0, 20'h00400, 32'h0);
        pushExp(EV_RD, t0 + 1, 20'h00400, 32'h0, 1'b0);
        pushExp(EV_RV, t0 + 3, 20'h00400, 32'hCAFE_0001, 1'b0);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 20'h0, 32'h0);
        checkOutput("rd_addr_T1", 32'(bus.o_user_addr), 32'h00400);
        waitCycles(1);
        setAck(1'b1, 32'hCAFE_0001);
        checkOutput("rd_addr_T2", 32'(bus.o_user_addr), 32'h00400);
        waitCycles(1);
        setAck(1'b0, 32'h0);
        checkOutput("rd_addr_T3", 32'(bus.o_user_addr), 32'h00400);
        waitCycles(1);
        checkOutput("rd_ready_T4", 32'(bus.o_host_ready), 32'd1);

        // No ack for a long time, then a late ack at T20
        t0 = cyc;
        applyStimulus(1'b1, 1'b0, 20'h00010, 32'h0);
        pushExp(EV_RD, t0 + 1, 20'h00010, 32'h0, 1'b0);
`ifdef USER_REG_TIMEOUT_EN
        pushExp(EV_RV, t0 + 17, 20'h00010, 32'hFFFF_FFFF, 1'b1);
`else
        pushExp(EV_RV, t0 + 21, 20'h00010, 32'h0000_BEEF, 1'b0);
`endif
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 20'h0, 32'h0);
        waitCycles(19);
        setAck(1'b1, 32'h0000_BEEF);
        waitCycles(1);
        setAck(1'b0, 32'h0);
        waitCycles(4);
        checkOutput("late_ack_single_completion", 32'(expQ.size()), 32'd0);

        // Ack exactly on the timeout boundary, held for three cycles
        t0 = cyc;
        applyStimulus(1'b1, 1'b0, 20'h00020, 32'h0);
        pushExp(EV_RD, t0 + 1, 20'h00020, 32'h0, 1'b0);
        pushExp(EV_RV, t0 + 17, 20'h00020, 32'h0000_00A5, 1'b0);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 20'h0, 32'h0);
        waitCycles(15);
        setAck(1'b1, 32'h0000_00A5);
        waitCycles(3);
        setAck(1'b0, 32'h0);
        waitCycles(1);
        checkOutput("boundary_ready_T20", 32'(bus.o_host_ready), 32'd1);

        // Back-to-back write, read, write with valid held high
        t0 = cyc;
        applyStimulus(1'b1, 1'b1, 20'h00500, 32'hA5A5_0001);
        pushExp(EV_WR, t0 + 1, 20'h00500, 32'hA5A5_0001, 1'b0);
        pushExp(EV_RD, t0 + 3, 20'h00600, 32'h0, 1'b0);
        pushExp(EV_RV, t0 + 5, 20'h00600, 32'hCAFE_0002, 1'b0);
        pushExp(EV_WR, t0 + 7, 20'h00700, 32'h0000_0777, 1'b0);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 20'h00600, 32'h0);
        waitCycles(2);
        applyStimulus(1'b1, 1'b1, 20'h00700, 32'h0000_0777);
        waitCycles(1);
        setAck(1'b1, 32'hCAFE_0002);
        waitCycles(1);
        setAck(1'b0, 32'h0);
        waitCycles(2);
        applyStimulus(1'b0, 1'b0, 20'h0, 32'h0);
        waitCycles(2);
        checkOutput("b2b_all_seen", 32'(expQ.size()), 32'd0);

        // Reset pulse in the middle of a read, then stale acks
        t0 = cyc;
        applyStimulus(1'b1, 1'b0, 20'h00800, 32'h0);
        pushExp(EV_RD, t0 + 1, 20'h00800, 32'h0, 1'b0);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 20'h0, 32'h0);
        waitCycles(1);
        rst = 1'b1;
        waitCycles(1);
        checkAllZero("midrst");
        rst = 1'b0;
        setAck(1'b1, 32'h0000_DEAD);
        waitCycles(1);
        checkOutput("midrst_ready_after", 32'(bus.o_host_ready), 32'd1);
        waitCycles(3);
        setAck(1'b0, 32'h0);
        waitCycles(2);
        checkOutput("midrst_no_completion", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
